// File: rtl/sp_pkg.sv
// Shared types and constants for the SP frame sequencer: FSM states, stage
// opcodes and default frame geometry.
package sp_pkg;

  localparam int DW_DEF      = 16;
  localparam int NWORDS_DEF  = 6;
  localparam int NSTAGES_DEF = 3;

  typedef enum logic [2:0] {
    IDLE,
    LD_MODE,
    LD_DATA,
    STAGE,
    OUT
  } state_t;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_REV  = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_PSUM = 3'd3;
  localparam logic [2:0] OP_NEG  = 3'd4;
  localparam logic [2:0] OP_ROTL = 3'd5;
  localparam logic [2:0] OP_ASR  = 3'd6;
  localparam logic [2:0] OP_SWAP = 3'd7;

endpackage

// File: rtl/sp_elem_op.sv
// Per-element stage unit: maps the element index to a source index and
// computes the result word plus the running prefix-sum accumulator.
module sp_elem_op
  import sp_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int NWORDS = NWORDS_DEF,
  parameter int IW     = $clog2(NWORDS)
) (
  input  logic [2:0]    op,
  input  logic [IW-1:0] i,
  input  logic [DW-1:0] word,
  input  logic [DW-1:0] acc,
  output logic [IW-1:0] idx,
  output logic [DW-1:0] result,
  output logic [DW-1:0] acc_next
);

  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  logic [DW-1:0] sum;

  always_comb begin
    idx      = i;
    result   = word;
    acc_next = acc;
    // Element 0 restarts the running sum so no clear cycle is needed per stage.
    sum      = ((i == '0) ? '0 : acc) + word;
    case (op)
      OP_REV:  idx = LAST - i;
      OP_ROTL: idx = (i == LAST) ? '0 : i + 1'b1;
      OP_SWAP: idx = i ^ IW'(1);
      OP_INC:  result = word + 1'b1;
      OP_PSUM: begin
        result   = sum;
        acc_next = sum;
      end
      OP_NEG:  result = '0 - word;
      OP_ASR:  result = {word[DW-1], word[DW-1:1]};
      default: ;
    endcase
  end

endmodule

// File: rtl/sp_frame_sequencer.sv
// Frame sequencer: loads 3 mode words and 6 data words, runs three ping-pong
// stages through sp_elem_op, then streams the result buffer out.
module sp_frame_sequencer
  import sp_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int NWORDS  = NWORDS_DEF,
  parameter int NSTAGES = NSTAGES_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  input  logic [2:0]    in_mode,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          err
);

  localparam int IW = $clog2(NWORDS);
  localparam int SW = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
  localparam logic [IW-1:0] EL_LAST = IW'(NWORDS - 1);
  localparam logic [SW-1:0] ST_LAST = SW'(NSTAGES - 1);

  // Handshake: in_valid qualifies every frame cycle; a frame is NSTAGES+NWORDS
  // back-to-back valid cycles, out_valid marks each result word, no backpressure.
  state_t        state;
  state_t        state_n;
  logic [IW-1:0] elc;
  logic [SW-1:0] stc;
  logic [2:0]    mode [NSTAGES];
  logic [DW-1:0] buf_a [NWORDS];
  logic [DW-1:0] buf_b [NWORDS];
  logic [DW-1:0] acc;
  logic [DW-1:0] acc_n;
  logic [DW-1:0] src_word;
  logic [DW-1:0] res;
  logic [IW-1:0] src_idx;
  logic [2:0]    cur_op;
  logic          viol;
  logic          viol_q;
  logic          err_n;

  assign cur_op = mode[stc];
  // Even stages read A and write B, odd stages the reverse; with an odd stage
  // count the final result lands in B.
  assign src_word = stc[0] ? buf_b[src_idx] : buf_a[src_idx];
  assign viol = in_valid && (state == STAGE || state == OUT);

  sp_elem_op #(
    .DW     (DW),
    .NWORDS (NWORDS),
    .IW     (IW)
  ) u_elem_op (
    .op       (cur_op),
    .i        (elc),
    .word     (src_word),
    .acc      (acc),
    .idx      (src_idx),
    .result   (res),
    .acc_next (acc_n)
  );

  always_comb begin
    state_n = state;
    err_n   = viol && !viol_q;
    case (state)
      IDLE:    if (in_valid) state_n = LD_MODE;
      LD_MODE: begin
        if (!in_valid) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else if (stc == ST_LAST) begin
          state_n = LD_DATA;
        end
      end
      LD_DATA: begin
        if (!in_valid) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else if (elc == EL_LAST) begin
          state_n = STAGE;
        end
      end
      STAGE:   if (stc == ST_LAST && elc == EL_LAST) state_n = OUT;
      OUT:     if (elc == EL_LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      elc       <= '0;
      stc       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      viol_q    <= 1'b0;
      for (int k = 0; k < NSTAGES; k++) mode[k] <= '0;
      for (int k = 0; k < NWORDS; k++) begin
        buf_a[k] <= '0;
        buf_b[k] <= '0;
      end
    end else begin
      err       <= err_n;
      viol_q    <= viol;
      // Outputs are registered one cycle behind OUT, so busy covers that tail.
      busy      <= (state_n != IDLE) || (state == OUT);
      out_valid <= 1'b0;
      out_data  <= '0;
      case (state)
        IDLE: begin
          elc <= '0;
          stc <= '0;
          if (in_valid) begin
            mode[0] <= in_mode;
            stc     <= SW'(1);
          end
        end
        LD_MODE: begin
          if (!in_valid) begin
            stc <= '0;
          end else begin
            mode[stc] <= in_mode;
            stc       <= (stc == ST_LAST) ? '0 : stc + 1'b1;
          end
        end
        LD_DATA: begin
          if (!in_valid) begin
            elc <= '0;
          end else begin
            buf_a[elc] <= in_data;
            elc        <= (elc == EL_LAST) ? '0 : elc + 1'b1;
          end
        end
        STAGE: begin
          acc <= acc_n;
          if (stc[0]) buf_a[elc] <= res;
          else        buf_b[elc] <= res;
          if (elc == EL_LAST) begin
            elc <= '0;
            stc <= (stc == ST_LAST) ? '0 : stc + 1'b1;
          end else begin
            elc <= elc + 1'b1;
          end
        end
        OUT: begin
          out_valid <= 1'b1;
          out_data  <= buf_b[elc];
          elc       <= (elc == EL_LAST) ? '0 : elc + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_frame_sequencer.sv
// Bench for sp_frame_sequencer: cycle-stamped behavioural model, per-cycle
// compare process, directed literal frames and randomized frames.
module tb_sp_frame_sequencer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid;
  logic [2:0]    in_mode;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          err;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  // Model state: frame tracking by cycle stamps, expectations keyed by cycle.
  bit            ld        = 1'b0;
  int            ldpos     = 0;
  int            proc_e    = -1000;
  bit            prev_viol = 1'b0;
  bit            viol_s;
  logic [2:0]    mm [3];
  logic [DW-1:0] md [6];
  logic [DW-1:0] mres [6];
  logic [DW-1:0] exp_data [int];
  bit            exp_busy [int];
  bit            exp_err [int];
  logic [DW-1:0] exp_q [$];

  sp_frame_sequencer dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .err       (err)
  );

  // Clock and reset
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [DW-1:0] act,
                                input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic void compute_frame();
    logic [DW-1:0] cur [6];
    logic [DW-1:0] nxt [6];
    logic [DW-1:0] run;
    run = '0;
    for (int i = 0; i < 6; i++) cur[i] = md[i];
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < 6; i++) begin
        case (mm[s])
          3'd0: nxt[i] = cur[i];
          3'd1: nxt[i] = cur[5 - i];
          3'd2: nxt[i] = cur[i] + 16'd1;
          3'd3: begin
            run    = ((i == 0) ? 16'd0 : run) + cur[i];
            nxt[i] = run;
          end
          3'd4: nxt[i] = 16'd0 - cur[i];
          3'd5: nxt[i] = cur[(i + 1) % 6];
          3'd6: nxt[i] = $signed(cur[i]) >>> 1;
          default: nxt[i] = cur[i ^ 1];
        endcase
      end
      for (int i = 0; i < 6; i++) cur[i] = nxt[i];
    end
    for (int i = 0; i < 6; i++) mres[i] = cur[i];
  endfunction

  task automatic model_clear();
    exp_data.delete();
    exp_busy.delete();
    exp_err.delete();
    exp_q.delete();
    ld        = 1'b0;
    proc_e    = -1000;
    prev_viol = 1'b0;
  endtask

  // Model: observe what the DUT samples on each edge, stamp expectations.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rstn) begin
      viol_s = 1'b0;
      if (cyc >= proc_e + 1 && cyc <= proc_e + 24) begin
        viol_s = in_valid;
        if (viol_s && !prev_viol) exp_err[cyc] = 1'b1;
      end else if (ld) begin
        if (!in_valid) begin
          exp_err[cyc] = 1'b1;
          ld = 1'b0;
        end else begin
          exp_busy[cyc] = 1'b1;
          if (ldpos < 3) mm[ldpos] = in_mode;
          else           md[ldpos - 3] = in_data;
          if (ldpos == 8) begin
            ld     = 1'b0;
            proc_e = cyc;
            compute_frame();
            for (int k = 1; k <= 24; k++) exp_busy[cyc + k] = 1'b1;
            for (int k = 0; k < 6; k++) begin
              exp_data[cyc + 19 + k] = mres[k];
              exp_q.push_back(mres[k]);
            end
          end
          ldpos++;
        end
      end else if (in_valid) begin
        ld            = 1'b1;
        mm[0]         = in_mode;
        exp_busy[cyc] = 1'b1;
        ldpos         = 1;
      end
      prev_viol = viol_s;
    end
  end

  // Scoreboard / compare process
  always @(negedge clk) begin
    bit ev;
    ev = exp_data.exists(cyc);
    check("out_valid", {15'd0, out_valid}, {15'd0, ev});
    check("out_data", out_data, ev ? exp_data[cyc] : 16'd0);
    check("busy", {15'd0, busy}, {15'd0, exp_busy.exists(cyc)});
    check("err", {15'd0, err}, {15'd0, exp_err.exists(cyc)});
    if (out_valid) begin
      if (exp_q.size() == 0) check("scoreboard_empty", 16'd1, 16'd0);
      else check("scoreboard", out_data, exp_q.pop_front());
    end
  end

  // Driver tasks
  task automatic send_frame(input logic [2:0] m [3], input logic [DW-1:0] d [6],
                            input int nvalid, output int e);
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      in_valid = (c < nvalid);
      if (c < 3) in_mode = m[c];
      else       in_mode = 3'($urandom);
      if (c >= 3) in_data = d[c - 3];
      else        in_data = 16'($urandom);
    end
    e = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mode  = 3'($urandom);
    in_data  = 16'($urandom);
  endtask

  task automatic idle_until(input int target, input int lo, input int hi, input bit rnd);
    while (cyc < target) begin
      @(posedge clk); #1;
      if (cyc + 1 >= lo && cyc + 1 <= hi)
        in_valid = rnd ? ($urandom_range(0, 3) == 0) : 1'b1;
      else
        in_valid = 1'b0;
      in_mode = 3'($urandom);
      in_data = 16'($urandom);
    end
  endtask

  task automatic check_lit(input logic [DW-1:0] lit [6], input int e);
    int w;
    w = 0;
    @(negedge clk);
    while (!out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("latency", 16'(cyc - e), 16'd19);
    for (int k = 0; k < 6; k++) begin
      check("literal", out_data, lit[k]);
      @(negedge clk);
    end
  endtask

  initial begin
    logic [2:0]    m [3];
    logic [DW-1:0] d [6];
    logic [DW-1:0] lit [6];
    int            e;
    int            nv;
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_mode  = '0;
    in_data  = '0;
    repeat (4) @(posedge clk);
    #1 rstn = 1'b1;
    idle_until(cyc + 2, 0, -1, 1'b0);

    m = '{3'd0, 3'd0, 3'd0};
    d = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    send_frame(m, d, 9, e);
    lit = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    check_lit(lit, e);

    m = '{3'd1, 3'd2, 3'd0};
    send_frame(m, d, 9, e);
    lit = '{16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2};
    check_lit(lit, e);

    m = '{3'd3, 3'd5, 3'd7};
    send_frame(m, d, 9, e);
    lit = '{16'd6, 16'd3, 16'd15, 16'd10, 16'd1, 16'd21};
    check_lit(lit, e);

    m = '{3'd2, 3'd4, 3'd6};
    d = '{16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 16'h0002};
    send_frame(m, d, 9, e);
    lit = '{16'h0000, 16'h3FFF, 16'hFFFF, 16'hC000, 16'hFFFF, 16'hFFFE};
    check_lit(lit, e);

    // Aborted frame followed by a clean one
    m = '{3'd0, 3'd0, 3'd0};
    send_frame(m, d, 4, e);
    idle_until(cyc + 5, 0, -1, 1'b0);
    d = '{16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14};
    send_frame(m, d, 9, e);
    lit = '{16'd9, 16'd10, 16'd11, 16'd12, 16'd13, 16'd14};
    check_lit(lit, e);

    // Reset in the middle of the stage phase
    m = '{3'd3, 3'd1, 3'd2};
    send_frame(m, d, 9, e);
    idle_until(cyc + 5, 0, -1, 1'b0);
    rstn = 1'b0;
    model_clear();
    idle_until(cyc + 3, 0, -1, 1'b0);
    rstn = 1'b1;
    idle_until(cyc + 40, 0, -1, 1'b0);

    // in_valid held during OUT
    m = '{3'd5, 3'd2, 3'd4};
    send_frame(m, d, 9, e);
    idle_until(e + 26, e + 20, e + 22, 1'b0);

    // Randomized frames: aborts, violations, back-to-back starts
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < 3; k++) m[k] = 3'($urandom);
      for (int k = 0; k < 6; k++) d[k] = 16'($urandom);
      nv = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 8) : 9;
      send_frame(m, d, nv, e);
      if (nv == 9) idle_until(e + 23 + $urandom_range(0, 3), e + 2, e + 20, 1'b1);
      else         idle_until(cyc + $urandom_range(1, 3), 0, -1, 1'b0);
    end

    idle_until(cyc + 40, 0, -1, 1'b0);
    check("leftover", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
